// File: rtl/lock_pkg.sv
// Shared digital-lock definitions: key codes, entry FSM encoding and default code length.
package lock_pkg;

   localparam int unsigned DIGITS_DEFAULT = 4;

   localparam logic [3:0] KEY_CLEAR = 4'hA;
   localparam logic [3:0] KEY_ENTER = 4'hB;
   localparam logic [3:0] KEY_BKSP  = 4'hC;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_SUBMIT  = 2'd2,
      ST_WAIT    = 2'd3
   } entry_state_e;

   function automatic logic is_digit(input logic [3:0] k);
      return k <= 4'h9;
   endfunction

endpackage

// File: rtl/entry_timer.sv
// Inactivity down-counter: reloads on restart, counts while running, flags zero as expiry.
module entry_timer #(
   parameter int unsigned CYCLES = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic restart_i,
   input  logic run_i,
   output logic expire_o
);

   localparam int unsigned CW = (CYCLES > 2) ? $clog2(CYCLES) : 1;
   localparam logic [CW-1:0] LOAD = CW'(CYCLES - 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= LOAD;
      end else if (restart_i) begin
         cnt_q <= LOAD;
      end else if (run_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - CW'(1);
      end
   end

   // Expiry is a decode of the counter register only; the caller qualifies it.
   assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/keypad_entry.sv
// Keypad entry stage: collects digits, edits, and hands a full code to the lock control path.
// Optional inactivity timeout is enabled by defining KEYPAD_TIMEOUT_EN.
module keypad_entry
   import lock_pkg::*;
#(
   parameter int unsigned DIGITS      = DIGITS_DEFAULT,
   parameter int unsigned TIMEOUT_CYC = 1000
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         key_valid,
   input  logic [3:0]                   key_code,
   input  logic                         done,
   output logic                         start,
   output logic [4*DIGITS-1:0]          code,
   output logic [$clog2(DIGITS+1)-1:0]  digit_count,
   output logic                         ready,
   output logic                         entry_err,
   output logic                         timeout
);

   localparam int unsigned CODE_W = 4 * DIGITS;
   localparam int unsigned CNT_W  = $clog2(DIGITS + 1);

   entry_state_e      state_q, state_d;
   logic [CODE_W-1:0] code_q, code_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              start_q, ready_q, ready_d;
   logic              err_q, err_d, tmo_q, tmo_d;
   logic              key_acc;
   logic              expire;

   assign key_acc = key_valid && ready_q;

`ifdef KEYPAD_TIMEOUT_EN
   logic timer_zero;

   entry_timer #(
      .CYCLES (TIMEOUT_CYC)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .restart_i (key_acc),
      .run_i     (state_q == ST_COLLECT),
      .expire_o  (timer_zero)
   );

   // An accepted key on the expiry cycle wins over the timeout.
   assign expire = (state_q == ST_COLLECT) && !key_acc && timer_zero;
`else
   logic unused_timeout_cyc;
   assign unused_timeout_cyc = ^TIMEOUT_CYC;
   assign expire             = 1'b0;
`endif

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      count_d = count_q;
      err_d   = 1'b0;
      tmo_d   = 1'b0;
      case (state_q)
         ST_IDLE, ST_COLLECT: begin
            if (key_acc) begin
               if (is_digit(key_code)) begin
                  if (count_q < CNT_W'(DIGITS)) begin
                     code_d  = CODE_W'({code_q, key_code});
                     count_d = count_q + CNT_W'(1);
                     state_d = ST_COLLECT;
                  end
               end else if (key_code == KEY_BKSP) begin
                  if (count_q != '0) begin
                     code_d  = code_q >> 4;
                     count_d = count_q - CNT_W'(1);
                     if (count_q == CNT_W'(1)) state_d = ST_IDLE;
                  end
               end else if (key_code == KEY_CLEAR) begin
                  code_d  = '0;
                  count_d = '0;
                  state_d = ST_IDLE;
               end else if (key_code == KEY_ENTER) begin
                  if (count_q == CNT_W'(DIGITS)) begin
                     state_d = ST_SUBMIT;
                  end else begin
                     err_d   = 1'b1;
                     code_d  = '0;
                     count_d = '0;
                     state_d = ST_IDLE;
                  end
               end
            end else if (expire) begin
               tmo_d   = 1'b1;
               code_d  = '0;
               count_d = '0;
               state_d = ST_IDLE;
            end
         end
         ST_SUBMIT: state_d = ST_WAIT;
         ST_WAIT: begin
            if (done) begin
               code_d  = '0;
               count_d = '0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      ready_d = ((state_d == ST_IDLE) || (state_d == ST_COLLECT)) && !done;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         code_q  <= '0;
         count_q <= '0;
         start_q <= 1'b0;
         ready_q <= !done;
         err_q   <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         count_q <= count_d;
         start_q <= (state_q == ST_SUBMIT);
         ready_q <= ready_d;
         err_q   <= err_d;
         tmo_q   <= tmo_d;
      end
   end

   assign start       = start_q;
   assign code        = code_q;
   assign digit_count = count_q;
   assign ready       = ready_q;
   assign entry_err   = err_q;
   assign timeout     = tmo_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Randomised self-checking bench for keypad_entry against a digit-queue reference model.
module tb_keypad_entry;

   localparam int unsigned DIGITS = 4;
   localparam int unsigned TCYC   = 8;
`ifdef KEYPAD_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   localparam int P_ENTRY  = 0;
   localparam int P_SUBMIT = 1;
   localparam int P_WAIT   = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        done;
   logic        start;
   logic [15:0] code;
   logic [2:0]  digit_count;
   logic        ready;
   logic        entry_err;
   logic        timeout;

   always #5 clk = ~clk;

   keypad_entry #(
      .DIGITS      (DIGITS),
      .TIMEOUT_CYC (TCYC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .key_valid   (key_valid),
      .key_code    (key_code),
      .done        (done),
      .start       (start),
      .code        (code),
      .digit_count (digit_count),
      .ready       (ready),
      .entry_err   (entry_err),
      .timeout     (timeout)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Reference model: typed digits, oldest first, plus a coarse phase.
   int digits_q[$];
   int phase   = P_ENTRY;
   int idle    = 0;
   bit m_start = 1'b0;
   bit m_err   = 1'b0;
   bit m_tmo   = 1'b0;
   bit m_ready = 1'b1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [63:0] model_code();
      logic [63:0] v = '0;
      foreach (digits_q[i]) v = v * 16 + 64'(digits_q[i]);
      return v;
   endfunction

   task automatic model_step(input bit r, input bit kv, input logic [3:0] kc, input bit dn);
      bit acc;
      acc = kv && m_ready;
      if (r) begin
         digits_q.delete();
         phase   = P_ENTRY;
         idle    = 0;
         m_start = 1'b0;
         m_err   = 1'b0;
         m_tmo   = 1'b0;
         m_ready = !dn;
         return;
      end
      m_start = (phase == P_SUBMIT);
      m_err   = 1'b0;
      m_tmo   = 1'b0;
      if (phase == P_ENTRY) begin
         if (acc) begin
            idle = 0;
            if (kc <= 4'h9) begin
               if (digits_q.size() < DIGITS) digits_q.push_back(int'(kc));
            end else if (kc == 4'hC) begin
               if (digits_q.size() > 0) void'(digits_q.pop_back());
            end else if (kc == 4'hA) begin
               digits_q.delete();
            end else if (kc == 4'hB) begin
               if (digits_q.size() == DIGITS) phase = P_SUBMIT;
               else begin
                  m_err = 1'b1;
                  digits_q.delete();
               end
            end
         end else if (TMO_EN && digits_q.size() > 0) begin
            idle++;
            if (idle == TCYC) begin
               m_tmo = 1'b1;
               idle  = 0;
               digits_q.delete();
            end
         end
      end else if (phase == P_SUBMIT) begin
         phase = P_WAIT;
      end else if (dn) begin
         digits_q.delete();
         phase = P_ENTRY;
      end
      m_ready = (phase == P_ENTRY) && !dn;
   endtask

   task automatic tick(input bit r, input bit kv, input logic [3:0] kc, input bit dn);
      rst       = r;
      key_valid = kv;
      key_code  = kc;
      done      = dn;
      @(posedge clk);
      model_step(r, kv, kc, dn);
      @(negedge clk);
      cyc++;
      check("code",        64'(code),        model_code());
      check("digit_count", 64'(digit_count), 64'(digits_q.size()));
      check("start",       64'(start),       64'(m_start));
      check("ready",       64'(ready),       64'(m_ready));
      check("entry_err",   64'(entry_err),   64'(m_err));
      check("timeout",     64'(timeout),     64'(m_tmo));
   endtask

   task automatic key(input logic [3:0] k);
      tick(1'b0, 1'b1, k, 1'b0);
   endtask

   task automatic idle_cycles(input int n, input bit dn);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 4'h0, dn);
   endtask

   initial begin
      bit dn_r = 1'b0;
      int r;
      logic [3:0] kc;

      tick(1'b1, 1'b0, 4'h0, 1'b0);
      tick(1'b1, 1'b0, 4'h0, 1'b0);

      // Full code, submit, then release via done.
      key(4'h1); key(4'h2); key(4'h3); key(4'h4); key(4'hB);
      idle_cycles(3, 1'b0);
      idle_cycles(2, 1'b1);
      idle_cycles(2, 1'b0);

      // Short ENTER, ENTER on empty entry, CLEAR in IDLE.
      key(4'h5); key(4'h6); key(4'hB);
      key(4'hB); key(4'hA); key(4'hC);

      // Editing, saturation, ignored codes, and keys locked out in WAIT.
      key(4'h7); key(4'h8); key(4'h9); key(4'hC); key(4'h1); key(4'h2);
      key(4'h3); key(4'hE); key(4'hB);
      key(4'h0); key(4'hA);
      tick(1'b0, 1'b1, 4'h5, 1'b1);
      idle_cycles(2, 1'b1);
      idle_cycles(2, 1'b0);

      // Inactivity: expiry after TCYC idle cycles; a key on the 7th cycle restarts.
      key(4'h4);
      idle_cycles(TCYC + 1, 1'b0);
      key(4'h4);
      idle_cycles(TCYC - 2, 1'b0);
      key(4'h6);
      idle_cycles(TCYC - 1, 1'b0);
      key(4'h9);
      idle_cycles(TCYC + 1, 1'b0);

      // Reset during the SUBMIT cycle.
      key(4'h1); key(4'h2); key(4'h3); key(4'h4); key(4'hB);
      tick(1'b1, 1'b0, 4'h0, 1'b0);
      idle_cycles(2, 1'b0);

      // Randomised traffic with random done levels and occasional reset.
      for (int i = 0; i < 4000; i++) begin
         r = int'($urandom_range(0, 19));
         if (r < 11)      kc = 4'(r % 10);
         else if (r < 14) kc = 4'hB;
         else if (r < 16) kc = 4'hC;
         else if (r < 17) kc = 4'hA;
         else             kc = 4'(13 + (r - 17));
         if ($urandom_range(0, 7) == 0) dn_r = !dn_r;
         tick($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0, kc, dn_r);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
